voice_allocator: RTL and testbench

//  Polyphonic voice allocator downstream of the touch-keyboard note decoder.

---
 rtl/voice_allocator.sv | 158 +++++++++++++++
 tb/tb_voice_allocator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: turns per-key gate/trigger events into voice assignments.
// Optional feature: define VOICE_STEAL_EN to steal the oldest voice when all voices are busy.
module voice_allocator #(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = $clog2(NUM_KEYS),
  parameter int AGE_W      = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_KEYS-1:0]         gate_in,
  input  logic [NUM_KEYS-1:0]         trigger_in,
  output logic [NUM_VOICES-1:0]       voice_active_out,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key_out,
  output logic [NUM_VOICES-1:0]       voice_trig_out,
  output logic [NUM_VOICES-1:0]       voice_rel_out,
  output logic                        overflow_out
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_KEYS-1:0]   pend_on_q, pend_off_q, gate_prev_q;
  logic [NUM_KEYS-1:0]   clr_on, clr_off;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [KEY_W-1:0]      key_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_d, trig_d, rel_d;
  logic                  ovf_d;

  logic                  off_any, on_any;
  logic [KEY_W-1:0]      off_key, on_key;
  logic [NUM_VOICES-1:0] hold_oh, free_oh, steal_oh, sel_oh;

  // Lowest pending key in each mask; descending scan leaves the lowest index.
  always_comb begin
    off_any = 1'b0;
    on_any  = 1'b0;
    off_key = '0;
    on_key  = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_off_q[k]) begin
        off_any = 1'b1;
        off_key = KEY_W'(k);
      end
      if (pend_on_q[k]) begin
        on_any = 1'b1;
        on_key = KEY_W'(k);
      end
    end
  end

  always_comb begin
    hold_oh = '0;
    free_oh = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active_out[v] && key_q[v] == on_key) hold_oh[v] = 1'b1;
      if (!voice_active_out[v]) free_oh = NUM_VOICES'(1) << v;
    end
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] best_age;

  // Oldest voice; strict compare keeps the lowest index on ties.
  always_comb begin
    best_age = '0;
    steal_oh = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (v == 0 || age_q[v] > best_age) begin
        best_age = age_q[v];
        steal_oh = NUM_VOICES'(1) << v;
      end
    end
  end
`else
  assign steal_oh = '0;
`endif

  always_comb begin
    active_d = voice_active_out;
    trig_d   = '0;
    rel_d    = '0;
    ovf_d    = 1'b0;
    sel_oh   = '0;
    clr_on   = '0;
    clr_off  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_d[v] = key_q[v];
      age_d[v] = age_q[v];
    end

    if (off_any) begin
      clr_off = NUM_KEYS'(1) << off_key;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_active_out[v] && key_q[v] == off_key) begin
          active_d[v] = 1'b0;
          rel_d[v]    = 1'b1;
        end
      end
    end else if (on_any) begin
      clr_on = NUM_KEYS'(1) << on_key;
      if (|hold_oh) begin
        sel_oh = hold_oh;
      end else if (|free_oh) begin
        sel_oh = free_oh;
      end else begin
        ovf_d  = 1'b1;
        sel_oh = steal_oh;
      end
      // The chosen voice restarts its age; every other sounding voice grows older.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (sel_oh[v]) begin
          active_d[v] = 1'b1;
          key_d[v]    = on_key;
          age_d[v]    = '0;
          trig_d[v]   = 1'b1;
        end else if (|sel_oh && voice_active_out[v] && age_q[v] != AGE_MAX) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pend_on_q        <= '0;
      pend_off_q       <= '0;
      gate_prev_q      <= '0;
      voice_active_out <= '0;
      voice_trig_out   <= '0;
      voice_rel_out    <= '0;
      overflow_out     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        age_q[v] <= '0;
      end
    end else begin
      // New events are OR-ed after the clear so a same-cycle re-arm is not lost.
      pend_on_q        <= (pend_on_q & ~clr_on) | trigger_in;
      pend_off_q       <= (pend_off_q & ~clr_off) | (gate_prev_q & ~gate_in);
      gate_prev_q      <= gate_in;
      voice_active_out <= active_d;
      voice_trig_out   <= trig_d;
      voice_rel_out    <= rel_d;
      overflow_out     <= ovf_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= key_d[v];
        age_q[v] <= age_d[v];
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
    assign voice_key_out[g*KEY_W +: KEY_W] = key_q[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event-level reference model with an expected queue, directed
// scenarios with literal expectations, and a randomized gate/trigger phase.
module tb_voice_allocator;
  localparam int NK   = 12;
  localparam int NV   = 4;
  localparam int KW   = 4;
  localparam int AMAX = 15;
  localparam int W    = 1 + NV + NV + NV + NV * KW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NK-1:0]    gate = '0;
  logic [NK-1:0]    trig = '0;
  logic [NV-1:0]    act, vtrig, vrel;
  logic [NV*KW-1:0] vkey;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  voice_allocator dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .gate_in         (gate),
    .trigger_in      (trig),
    .voice_active_out(act),
    .voice_key_out   (vkey),
    .voice_trig_out  (vtrig),
    .voice_rel_out   (vrel),
    .overflow_out    (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_act[NV];
  int m_key[NV];
  int m_age[NV];
  bit m_pon[NK];
  bit m_poff[NK];
  bit m_gprev[NK];

  function automatic void model_step();
    logic [NV-1:0]    e_trig = '0;
    logic [NV-1:0]    e_rel  = '0;
    logic             e_ovf  = 1'b0;
    logic [NV-1:0]    e_act;
    logic [NV*KW-1:0] e_key;
    int k = -1;
    int v = -1;
    for (int i = 0; i < NK; i++) if (m_poff[i] && k < 0) k = i;
    if (k >= 0) begin
      m_poff[k] = 1'b0;
      for (int u = 0; u < NV; u++)
        if (m_act[u] && m_key[u] == k) begin
          m_act[u] = 1'b0;
          e_rel[u] = 1'b1;
        end
    end else begin
      for (int i = 0; i < NK; i++) if (m_pon[i] && k < 0) k = i;
      if (k >= 0) begin
        m_pon[k] = 1'b0;
        for (int u = 0; u < NV; u++) if (m_act[u] && m_key[u] == k && v < 0) v = u;
        if (v < 0) for (int u = 0; u < NV; u++) if (!m_act[u] && v < 0) v = u;
        if (v < 0) begin
          e_ovf = 1'b1;
`ifdef VOICE_STEAL_EN
          v = 0;
          for (int u = 1; u < NV; u++) if (m_age[u] > m_age[v]) v = u;
`endif
        end
        if (v >= 0) begin
          for (int u = 0; u < NV; u++)
            if (u != v && m_act[u] && m_age[u] < AMAX) m_age[u]++;
          m_act[v]  = 1'b1;
          m_key[v]  = k;
          m_age[v]  = 0;
          e_trig[v] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (m_gprev[i] && !gate[i]) m_poff[i] = 1'b1;
      if (trig[i]) m_pon[i] = 1'b1;
      m_gprev[i] = gate[i];
    end
    for (int u = 0; u < NV; u++) begin
      e_act[u] = m_act[u];
      e_key[u*KW +: KW] = KW'(m_key[u]);
    end
    exp_q.push_back({e_ovf, e_rel, e_trig, e_act, e_key});
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NV; u++) begin
        m_act[u] = 1'b0;
        m_key[u] = 0;
        m_age[u] = 0;
      end
      for (int i = 0; i < NK; i++) begin
        m_pon[i]   = 1'b0;
        m_poff[i]  = 1'b0;
        m_gprev[i] = 1'b0;
      end
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        check("reset_outputs", 32'({ovf, vrel, vtrig, act, vkey}), 32'd0);
      end else if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("overflow", 32'(ovf), 32'(e[W-1]));
        check("rel", 32'(vrel), 32'(e[W-2 -: NV]));
        check("trig", 32'(vtrig), 32'(e[W-2-NV -: NV]));
        check("active", 32'(act), 32'(e[W-2-2*NV -: NV]));
        check("keys", 32'(vkey), 32'(e[NV*KW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NK-1:0] m);
    @(negedge clk);
    trig = m;
    gate = gate | m;
    @(negedge clk);
    trig = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_immediate", 32'({ovf, vrel, vtrig, act, vkey}), 32'd0);
    repeat (2) @(negedge clk);
    gate  = '0;
    trig  = '0;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NK-1:0] flips, nxt, held;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single note on then off
    press(12'h001);
    step();
    check("t2_active", 32'(act), 32'h1);
    check("t2_trig", 32'(vtrig), 32'h1);
    check("t2_key0", 32'(vkey[3:0]), 32'h0);
    @(negedge clk);
    gate[0] = 1'b0;
    step();
    check("t2_no_early_rel", 32'(vrel), 32'h0);
    step();
    check("t2_rel", 32'(vrel), 32'h1);
    check("t2_inactive", 32'(act), 32'h0);

    // Four keys in one cycle, allocated one per cycle
    do_reset();
    press(12'h00F);
    for (int i = 0; i < NV; i++) begin
      step();
      check("t3_trig", 32'(vtrig), 32'(1) << i);
      check("t3_key", 32'(vkey[i*KW +: KW]), 32'(i));
    end
    check("t3_all_active", 32'(act), 32'hF);

    // All voices busy, press key 7
    press(12'h080);
    step();
    check("t4_overflow", 32'(ovf), 32'h1);
`ifdef VOICE_STEAL_EN
    check("t4_trig", 32'(vtrig), 32'h1);
    check("t4_keys", 32'(vkey), 32'h3217);
`else
    check("t4_trig", 32'(vtrig), 32'h0);
    check("t4_keys", 32'(vkey), 32'h3210);
`endif

    // Release and press in the same cycle: release wins, freed voice reused
    do_reset();
    press(12'h00F);
    repeat (4) step();
    @(negedge clk);
    gate = (gate & ~12'h002) | 12'h020;
    trig = 12'h020;
    @(negedge clk);
    trig = '0;
    step();
    check("t5_rel", 32'(vrel), 32'h2);
    check("t5_active_gap", 32'(act), 32'hD);
    step();
    check("t5_trig", 32'(vtrig), 32'h2);
    check("t5_keys", 32'(vkey), 32'h3250);

    // Retrigger of a held key
    do_reset();
    press(12'h001);
    step();
    press(12'h004);
    step();
    check("t6_alloc_key", 32'(vkey[7:4]), 32'h2);
    press(12'h004);
    step();
    check("t6_retrig", 32'(vtrig), 32'h2);
    check("t6_active", 32'(act), 32'h3);
    check("t6_key_kept", 32'(vkey[7:4]), 32'h2);

    // Gate rising without trigger allocates nothing
    do_reset();
    @(negedge clk);
    gate = 12'h008;
    repeat (5) step();
    check("t1_gate_only", 32'(act), 32'h0);

    // Randomized gates, presses and retriggers
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) do_reset();
      @(negedge clk);
      flips = '0;
      for (int i = 0; i < NK; i++) if ($urandom_range(0, 19) == 0) flips[i] = 1'b1;
      nxt  = gate ^ flips;
      held = nxt & gate;
      trig = nxt & ~gate;
      if ($urandom_range(0, 9) == 0) trig = trig | (held & (NK'(1) << $urandom_range(0, NK - 1)));
      gate = nxt;
    end
    @(negedge clk);
    trig = '0;
    gate = '0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
